// File: rtl/lbdr_input_fifo.sv
// Per-input-port FWFT flit buffer feeding LBDR; returns one credit per popped flit.
// Optional write-side packet-framing checker enabled by FIFO_PKT_CHECK_EN.
module lbdr_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_credit, r_err;
  logic                  w_push, w_pop, w_overflow, w_pkt_err;
  logic [2:0]            w_fid_in;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign w_pop    = rd_en & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign w_push     = valid_in & (~full | w_pop);
  assign w_overflow = valid_in & full & ~w_pop;
  assign w_fid_in   = data_in[DATA_WIDTH-1 -: 3];

  assign data_out   = r_mem[r_rd_ptr];
  assign flit_id    = data_out[DATA_WIDTH-1 -: 3];
  assign dst_addr   = data_out[DATA_WIDTH-4 -: 4];
  assign credit_out = r_credit;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
      r_credit <= w_pop;
      if (w_overflow | w_pkt_err) r_err <= 1'b1;
    end
  end

`ifdef FIFO_PKT_CHECK_EN
  typedef enum logic {IDLE, IN_PKT} pkt_state_t;
  pkt_state_t r_state, w_state_nxt;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Framing is tracked on accepted flits only; offending flits are still stored.
  always_comb begin
    w_state_nxt = r_state;
    w_pkt_err   = 1'b0;
    if (w_push) begin
      case (w_fid_in)
        HEADER:  if (r_state == IDLE) w_state_nxt = IN_PKT; else w_pkt_err = 1'b1;
        PAYLOAD: if (r_state == IDLE) w_pkt_err = 1'b1;
        TAIL:    if (r_state == IN_PKT) w_state_nxt = IDLE; else w_pkt_err = 1'b1;
        default: w_pkt_err = 1'b1;
      endcase
    end
  end
`else
  logic [2:0] w_fid_unused;
  assign w_fid_unused = w_fid_in;
  assign w_pkt_err    = 1'b0;
`endif
endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Bench for lbdr_input_fifo: table-driven vectors plus hand sequences, queue scoreboard on data.
module tb_lbdr_input_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic          empty, full, credit_out, err;

  lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .flit_id(flit_id), .dst_addr(dst_addr), .empty(empty),
    .full(full), .credit_out(credit_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          r;
    bit          e_empty;
    bit          e_full;
    bit          e_credit;
    bit          e_err;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] q[$];

  function automatic logic [31:0] mk(input logic [2:0] id, input logic [3:0] dst, input int pl);
    return {id, dst, pl[24:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; valid_in = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
  endtask

  // Apply one cycle of inputs; scoreboard checks head data on every pop the model accepts.
  task automatic step(input bit v, input logic [31:0] d, input bit r);
    logic [DW-1:0] exp_d;
    bit pop;
    int sz;
    sz = q.size();
    pop = r && (sz > 0);
    valid_in = v; data_in = d; rd_en = r;
    if (pop) begin
      exp_d = q.pop_front();
      chk("pop_data", data_out, exp_d);
      chk("pop_flit_id", {29'd0, flit_id}, {29'd0, exp_d[31:29]});
      chk("pop_dst_addr", {28'd0, dst_addr}, {28'd0, exp_d[28:25]});
    end
    if (v && (sz < DEPTH || pop)) q.push_back(d);
    @(posedge clk);
    #1;
    valid_in = 1'b0; rd_en = 1'b0;
  endtask

  vec_t tv[10];

  initial begin
    logic [31:0] h, p1, p2, t, x;
    h  = mk(3'b001, 4'hA, 1);
    p1 = mk(3'b010, 4'h0, 2);
    p2 = mk(3'b010, 4'h0, 3);
    t  = mk(3'b100, 4'h0, 4);
    x  = mk(3'b010, 4'h5, 5);
    tv[0] = '{1, h,  0, 0, 0, 0, 0};
    tv[1] = '{1, p1, 0, 0, 0, 0, 0};
    tv[2] = '{1, p2, 0, 0, 0, 0, 0};
    tv[3] = '{1, t,  0, 0, 1, 0, 0};
    tv[4] = '{1, x,  0, 0, 1, 0, 1};
    tv[5] = '{0, '0, 1, 0, 0, 1, 1};
    tv[6] = '{0, '0, 1, 0, 0, 1, 1};
    tv[7] = '{0, '0, 1, 0, 0, 1, 1};
    tv[8] = '{0, '0, 1, 1, 0, 1, 1};
    tv[9] = '{0, '0, 0, 1, 0, 0, 1};

    // Reset held with traffic on the link
    rst = 1'b0; valid_in = 1'b1; data_in = h;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; valid_in = 1'b0;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_credit", {31'd0, credit_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Packet fill, overflow, drain with credits
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tv[i].v, tv[i].d, tv[i].r);
      chk($sformatf("tv%0d_empty", i), {31'd0, empty}, {31'd0, tv[i].e_empty});
      chk($sformatf("tv%0d_full", i), {31'd0, full}, {31'd0, tv[i].e_full});
      chk($sformatf("tv%0d_credit", i), {31'd0, credit_out}, {31'd0, tv[i].e_credit});
      chk($sformatf("tv%0d_err", i), {31'd0, err}, {31'd0, tv[i].e_err});
    end
    chk("drain_sb_empty", q.size(), 0);

    // Full with simultaneous push+pop, repeated across pointer wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, mk(3'b010, 4'(i), 100 + i), 0);
    chk("fill_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1, mk(3'b010, 4'(i), 200 + i), 1);
      chk($sformatf("pp%0d_full", i), {31'd0, full}, 32'd1);
      chk($sformatf("pp%0d_credit", i), {31'd0, credit_out}, 32'd1);
    end
    chk("pp_no_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1);
    chk("pp_drain_empty", {31'd0, empty}, 32'd1);

    // Empty with push+pop: pop ignored
    do_reset();
    step(1, h, 1);
    chk("ep_credit", {31'd0, credit_out}, 32'd0);
    chk("ep_empty", {31'd0, empty}, 32'd0);
    chk("ep_data", data_out, h);
    step(0, '0, 1);
    chk("ep_pop_credit", {31'd0, credit_out}, 32'd1);
    step(0, '0, 1);
    chk("ep_idle_pop_credit", {31'd0, credit_out}, 32'd0);

`ifdef FIFO_PKT_CHECK_EN
    do_reset();
    step(1, p1, 0);
    chk("pkt_payload_first_err", {31'd0, err}, 32'd1);
    do_reset();
    step(1, h, 0);
    chk("pkt_hdr1_err", {31'd0, err}, 32'd0);
    step(1, h, 0);
    chk("pkt_hdr_hdr_err", {31'd0, err}, 32'd1);
    do_reset();
    step(1, h, 0); step(1, p1, 1); step(1, t, 1); step(1, h, 1); step(1, t, 1);
    step(0, '0, 1);
    chk("pkt_legal_err", {31'd0, err}, 32'd0);
`else
    do_reset();
    step(1, p1, 0);
    step(1, h, 0);
    step(1, h, 0);
    chk("nopkt_no_err", {31'd0, err}, 32'd0);
    step(0, '0, 1); step(0, '0, 1); step(0, '0, 1);
    chk("nopkt_drain_empty", {31'd0, empty}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
